// File: rtl/mips150_ctrl_pipe.sv
// MIPS150 pipelined control: D-stage decode, X/M control registers, forwarding
// selects, load-use stall, control-flow flush and illegal-instruction counting.

module ALUdec (
   input  logic [5:0] funct,
   input  logic [5:0] opcode,
   output logic [3:0] alu_op
);
   always_comb begin
      alu_op = 4'd0;
      case (opcode)
         6'b000000:
            case (funct)
               6'b000000, 6'b000100: alu_op = 4'd8;   // SLL, SLLV
               6'b000011, 6'b000111: alu_op = 4'd9;   // SRA, SRAV
               6'b000010, 6'b000110: alu_op = 4'd10;  // SRL, SRLV
               6'b100011:            alu_op = 4'd1;
               6'b100100:            alu_op = 4'd4;
               6'b100101:            alu_op = 4'd5;
               6'b100110:            alu_op = 4'd6;
               6'b100111:            alu_op = 4'd11;
               6'b101010:            alu_op = 4'd2;
               6'b101011:            alu_op = 4'd3;
               default:              alu_op = 4'd0;
            endcase
         6'b001010: alu_op = 4'd2;
         6'b001011: alu_op = 4'd3;
         6'b001100: alu_op = 4'd4;
         6'b001101: alu_op = 4'd5;
         6'b001110: alu_op = 4'd6;
         6'b001111: alu_op = 4'd7;
         default:   alu_op = 4'd0;
      endcase
   end
endmodule

module mips150_ctrl_pipe #(
   parameter bit LOAD_USE_STALL    = 1'b1,
   parameter bit BRANCH_DELAY_SLOT = 1'b1,
   parameter int CNT_WIDTH         = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [31:0]          instr_d,
   input  logic                 valid_d,
   input  logic                 stall_ext,
   input  logic                 branch_taken_x,
   output logic                 x_valid,
   output logic [3:0]           x_alu_op,
   output logic                 x_alu_src,
   output logic                 x_sign_ext,
   output logic                 x_shamt_sel,
   output logic [2:0]           x_br_ctrl,
   output logic                 x_branch,
   output logic                 x_jump,
   output logic                 x_jr,
   output logic [1:0]           fwd_a_x,
   output logic [1:0]           fwd_b_x,
   output logic                 m_valid,
   output logic                 m_reg_write,
   output logic                 m_mem_to_reg,
   output logic                 m_link,
   output logic [1:0]           m_mem_write,
   output logic [2:0]           m_load_mask,
   output logic [4:0]           m_dest,
   output logic                 stall_d,
   output logic                 flush_d,
   output logic [CNT_WIDTH-1:0] illegal_cnt
);
   typedef struct packed {
      logic [3:0] alu_op;
      logic       alu_src, sign_ext, shamt_sel;
      logic [2:0] br_ctrl;
      logic       branch, jump, jr;
      logic       reg_write, mem_to_reg, link;
      logic [1:0] mem_write;
      logic [2:0] load_mask;
      logic [4:0] dest;
   } xctl_t;

   typedef struct packed {
      logic       reg_write, mem_to_reg, link;
      logic [1:0] mem_write;
      logic [2:0] load_mask;
      logic [4:0] dest;
   } mctl_t;

   logic [5:0] op, funct;
   logic [4:0] rs, rt, rd;
   logic       unused_shamt;
   assign op     = instr_d[31:26];
   assign rs     = instr_d[25:21];
   assign rt     = instr_d[20:16];
   assign rd     = instr_d[15:11];
   assign funct  = instr_d[5:0];
   assign unused_shamt = ^instr_d[10:6];

   logic [3:0] alu_op_d;
   ALUdec u_aludec (.funct(funct), .opcode(op), .alu_op(alu_op_d));

   xctl_t dec, x_q;
   mctl_t m_q;
   logic  legal, rd_rs, rd_rt;

   always_comb begin
      dec        = '0;
      dec.alu_op = alu_op_d;
      legal      = 1'b1;
      rd_rs      = 1'b1;
      rd_rt      = 1'b0;
      case (op)
         6'b000000: begin
            dec.dest      = rd;
            dec.reg_write = 1'b1;
            rd_rt         = 1'b1;
            case (funct)
               6'b000000, 6'b000010, 6'b000011: rd_rs = 1'b0;
               6'b000100, 6'b000110, 6'b000111: dec.shamt_sel = 1'b1;
               6'b001000: begin
                  dec.jr = 1'b1; dec.reg_write = 1'b0; dec.dest = '0; rd_rt = 1'b0;
               end
               6'b001001: begin
                  dec.jr = 1'b1; dec.link = 1'b1; rd_rt = 1'b0;
               end
               6'b100001, 6'b100011, 6'b100100, 6'b100101,
               6'b100110, 6'b100111, 6'b101010, 6'b101011: begin end
               default: legal = 1'b0;
            endcase
         end
         6'b000001: begin
            dec.branch = 1'b1; dec.sign_ext = 1'b1;
            case (rt)
               5'b00000: dec.br_ctrl = 3'b100;
               5'b00001: dec.br_ctrl = 3'b101;
               default:  legal = 1'b0;
            endcase
         end
         6'b000010: begin dec.jump = 1'b1; rd_rs = 1'b0; end
         6'b000011: begin
            dec.jump = 1'b1; dec.link = 1'b1; dec.reg_write = 1'b1;
            dec.dest = 5'd31; rd_rs = 1'b0;
         end
         // BEQ/BNE/BLEZ/BGTZ: low opcode bits are the compare kind
         6'b000100, 6'b000101, 6'b000110, 6'b000111: begin
            dec.branch = 1'b1; dec.sign_ext = 1'b1;
            dec.br_ctrl = {1'b0, op[1:0]};
            rd_rt = ~op[1];
         end
         6'b001001, 6'b001010, 6'b001011, 6'b001100,
         6'b001101, 6'b001110, 6'b001111: begin
            dec.alu_src = 1'b1; dec.sign_ext = ~op[2];
            dec.reg_write = 1'b1; dec.dest = rt;
            rd_rs = (op != 6'b001111);
         end
         6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101: begin
            dec.alu_src = 1'b1; dec.sign_ext = 1'b1;
            dec.reg_write = 1'b1; dec.mem_to_reg = 1'b1; dec.dest = rt;
            case (op[2:0])
               3'b000:  dec.load_mask = 3'b000;
               3'b001:  dec.load_mask = 3'b001;
               3'b011:  dec.load_mask = 3'b010;
               3'b100:  dec.load_mask = 3'b011;
               default: dec.load_mask = 3'b100;
            endcase
         end
         6'b101000, 6'b101001, 6'b101011: begin
            dec.alu_src = 1'b1; dec.sign_ext = 1'b1; rd_rt = 1'b1;
            dec.mem_write = (op[1:0] == 2'b00) ? 2'b01 :
                            (op[1:0] == 2'b01) ? 2'b10 : 2'b11;
         end
         default: legal = 1'b0;
      endcase
      if (!legal) begin
         dec = '0; rd_rs = 1'b0; rd_rt = 1'b0;
      end
   end

   logic d_live, load_use, flush, fwd_src;
   assign d_live   = valid_d & legal;
   assign load_use = LOAD_USE_STALL & x_valid & x_q.mem_to_reg & (|x_q.dest) & d_live &
                     ((rd_rs & (rs == x_q.dest)) | (rd_rt & (rt == x_q.dest)));
   assign flush    = ~BRANCH_DELAY_SLOT & x_valid &
                     ((x_q.branch & branch_taken_x) | x_q.jump | x_q.jr);
   // Current X is the producer that becomes M as the D instruction enters X
   assign fwd_src  = x_valid & x_q.reg_write & (|x_q.dest);

   assign stall_d = ~rst & (stall_ext | (load_use & ~flush));
   assign flush_d = ~rst & ~stall_ext & flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         x_q         <= '0;
         x_valid     <= 1'b0;
         fwd_a_x     <= 2'b00;
         fwd_b_x     <= 2'b00;
         m_q         <= '0;
         m_valid     <= 1'b0;
         illegal_cnt <= '0;
      end else if (!stall_ext) begin
         m_q     <= '{x_q.reg_write, x_q.mem_to_reg, x_q.link, x_q.mem_write,
                      x_q.load_mask, x_q.dest};
         m_valid <= x_valid;
         if (flush || load_use || !d_live) begin
            x_q     <= '0;
            x_valid <= 1'b0;
            fwd_a_x <= 2'b00;
            fwd_b_x <= 2'b00;
         end else begin
            x_q     <= dec;
            x_valid <= 1'b1;
            fwd_a_x <= {1'b0, fwd_src & (rs == x_q.dest)};
            fwd_b_x <= {1'b0, fwd_src & (rt == x_q.dest)};
         end
         if (!flush && valid_d && !legal && !(&illegal_cnt))
            illegal_cnt <= illegal_cnt + 1'b1;
      end
   end

   assign x_alu_op     = x_q.alu_op;
   assign x_alu_src    = x_q.alu_src;
   assign x_sign_ext   = x_q.sign_ext;
   assign x_shamt_sel  = x_q.shamt_sel;
   assign x_br_ctrl    = x_q.br_ctrl;
   assign x_branch     = x_q.branch;
   assign x_jump       = x_q.jump;
   assign x_jr         = x_q.jr;
   assign m_reg_write  = m_q.reg_write;
   assign m_mem_to_reg = m_q.mem_to_reg;
   assign m_link       = m_q.link;
   assign m_mem_write  = m_q.mem_write;
   assign m_load_mask  = m_q.load_mask;
   assign m_dest       = m_q.dest;
endmodule

// File: tb/tb_mips150_ctrl_pipe.sv
// Directed bench for mips150_ctrl_pipe: two configurations share one stimulus
// stream; expectations are queued per step and drained against the outputs.

module tb_mips150_ctrl_pipe;
   logic clk = 1'b0;
   logic rst, valid_d, stall_ext, branch_taken_x;
   logic [31:0] instr_d;
   always #5 clk = ~clk;

   // dut: delay slot, 16-bit counter
   logic x_valid, x_alu_src, x_sign_ext, x_shamt_sel, x_branch, x_jump, x_jr;
   logic [3:0] x_alu_op;
   logic [2:0] x_br_ctrl, m_load_mask;
   logic [1:0] fwd_a_x, fwd_b_x, m_mem_write;
   logic m_valid, m_reg_write, m_mem_to_reg, m_link, stall_d, flush_d;
   logic [4:0] m_dest;
   logic [15:0] illegal_cnt;

   // dut_b: no delay slot, 2-bit counter
   logic b_x_valid, b_x_alu_src, b_x_sign_ext, b_x_shamt_sel, b_x_branch, b_x_jump, b_x_jr;
   logic [3:0] b_x_alu_op;
   logic [2:0] b_x_br_ctrl, b_m_load_mask;
   logic [1:0] b_fwd_a_x, b_fwd_b_x, b_m_mem_write;
   logic b_m_valid, b_m_reg_write, b_m_mem_to_reg, b_m_link, b_stall_d, b_flush_d;
   logic [4:0] b_m_dest;
   logic [1:0] b_illegal_cnt;

   mips150_ctrl_pipe #(.LOAD_USE_STALL(1'b1), .BRANCH_DELAY_SLOT(1'b1), .CNT_WIDTH(16)) dut (
      .clk(clk), .rst(rst), .instr_d(instr_d), .valid_d(valid_d), .stall_ext(stall_ext),
      .branch_taken_x(branch_taken_x), .x_valid(x_valid), .x_alu_op(x_alu_op),
      .x_alu_src(x_alu_src), .x_sign_ext(x_sign_ext), .x_shamt_sel(x_shamt_sel),
      .x_br_ctrl(x_br_ctrl), .x_branch(x_branch), .x_jump(x_jump), .x_jr(x_jr),
      .fwd_a_x(fwd_a_x), .fwd_b_x(fwd_b_x), .m_valid(m_valid), .m_reg_write(m_reg_write),
      .m_mem_to_reg(m_mem_to_reg), .m_link(m_link), .m_mem_write(m_mem_write),
      .m_load_mask(m_load_mask), .m_dest(m_dest), .stall_d(stall_d), .flush_d(flush_d),
      .illegal_cnt(illegal_cnt));

   mips150_ctrl_pipe #(.LOAD_USE_STALL(1'b1), .BRANCH_DELAY_SLOT(1'b0), .CNT_WIDTH(2)) dut_b (
      .clk(clk), .rst(rst), .instr_d(instr_d), .valid_d(valid_d), .stall_ext(stall_ext),
      .branch_taken_x(branch_taken_x), .x_valid(b_x_valid), .x_alu_op(b_x_alu_op),
      .x_alu_src(b_x_alu_src), .x_sign_ext(b_x_sign_ext), .x_shamt_sel(b_x_shamt_sel),
      .x_br_ctrl(b_x_br_ctrl), .x_branch(b_x_branch), .x_jump(b_x_jump), .x_jr(b_x_jr),
      .fwd_a_x(b_fwd_a_x), .fwd_b_x(b_fwd_b_x), .m_valid(b_m_valid), .m_reg_write(b_m_reg_write),
      .m_mem_to_reg(b_m_mem_to_reg), .m_link(b_m_link), .m_mem_write(b_m_mem_write),
      .m_load_mask(b_m_load_mask), .m_dest(b_m_dest), .stall_d(b_stall_d), .flush_d(b_flush_d),
      .illegal_cnt(b_illegal_cnt));

   localparam int S_XV = 0, S_ALUOP = 1, S_ASRC = 2, S_SEXT = 3, S_BRC = 4, S_BR = 5,
                  S_J = 6, S_JR = 7, S_FA = 8, S_FB = 9, S_MV = 10, S_MRW = 11, S_MMR = 12,
                  S_MLK = 13, S_MMW = 14, S_MLM = 15, S_MDST = 16, S_STL = 17, S_FL = 18,
                  S_CNT = 19, S_ALL = 20, B_XV = 21, B_FL = 22, B_CNT = 23, B_STL = 24,
                  B_ALL = 25;

   function automatic logic [63:0] obs(input int s);
      case (s)
         S_XV:   return 64'(x_valid);
         S_ALUOP:return 64'(x_alu_op);
         S_ASRC: return 64'(x_alu_src);
         S_SEXT: return 64'(x_sign_ext);
         S_BRC:  return 64'(x_br_ctrl);
         S_BR:   return 64'(x_branch);
         S_J:    return 64'(x_jump);
         S_JR:   return 64'(x_jr);
         S_FA:   return 64'(fwd_a_x);
         S_FB:   return 64'(fwd_b_x);
         S_MV:   return 64'(m_valid);
         S_MRW:  return 64'(m_reg_write);
         S_MMR:  return 64'(m_mem_to_reg);
         S_MLK:  return 64'(m_link);
         S_MMW:  return 64'(m_mem_write);
         S_MLM:  return 64'(m_load_mask);
         S_MDST: return 64'(m_dest);
         S_STL:  return 64'(stall_d);
         S_FL:   return 64'(flush_d);
         S_CNT:  return 64'(illegal_cnt);
         S_ALL:  return 64'({x_valid, x_alu_op, x_alu_src, x_sign_ext, x_shamt_sel, x_br_ctrl,
                             x_branch, x_jump, x_jr, fwd_a_x, fwd_b_x, m_valid, m_reg_write,
                             m_mem_to_reg, m_link, m_mem_write, m_load_mask, m_dest,
                             stall_d, flush_d});
         B_XV:   return 64'(b_x_valid);
         B_FL:   return 64'(b_flush_d);
         B_CNT:  return 64'(b_illegal_cnt);
         B_STL:  return 64'(b_stall_d);
         B_ALL:  return 64'({b_x_valid, b_x_alu_op, b_x_alu_src, b_x_sign_ext, b_x_shamt_sel,
                             b_x_br_ctrl, b_x_branch, b_x_jump, b_x_jr, b_fwd_a_x, b_fwd_b_x,
                             b_m_valid, b_m_reg_write, b_m_mem_to_reg, b_m_link, b_m_mem_write,
                             b_m_load_mask, b_m_dest, b_stall_d, b_flush_d});
         default:return '1;
      endcase
   endfunction

   typedef struct {
      string       tag;
      int          sig;
      logic [63:0] val;
   } exp_t;

   exp_t q[$];
   int n_assert = 0;
   int n_fail   = 0;

   task automatic expect_val(input string tag, input int sig, input logic [63:0] val);
      exp_t e;
      e.tag = tag; e.sig = sig; e.val = val;
      q.push_back(e);
   endtask

   task automatic drain();
      exp_t e;
      #1;
      while (q.size() > 0) begin
         e = q.pop_front();
         n_assert++;
         assert (obs(e.sig) === e.val) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", e.tag, obs(e.sig), e.val);
         end
      end
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic drive(input logic [31:0] ins, input logic v);
      instr_d = ins; valid_d = v;
   endtask

   localparam logic [31:0] LW8   = 32'h8C880000, ADDU9 = 32'h01084821,
                           ADDI8 = 32'h24080005, ADDI0 = 32'h24000005,
                           ADDU0 = 32'h00004821, JAL   = 32'h0C000010,
                           JR31  = 32'h03E00008, BEQ   = 32'h10000001,
                           NOP   = 32'h00000000, ILL   = 32'hFC000000;

   initial begin
      rst = 1'b1; stall_ext = 1'b0; branch_taken_x = 1'b0;
      drive(NOP, 1'b0);
      step(); step();
      rst = 1'b0;
      expect_val("reset_all", S_ALL, 64'd0);
      expect_val("reset_cnt", S_CNT, 64'd0);
      expect_val("reset_all_b", B_ALL, 64'd0);
      expect_val("reset_cnt_b", B_CNT, 64'd0);
      drain();

      // load-use: LW $8 then ADDU reading $8
      drive(LW8, 1'b1);
      expect_val("lw_no_stall", S_STL, 64'd0);
      drain();
      step();
      drive(ADDU9, 1'b1);
      expect_val("lw_x_valid", S_XV, 64'd1);
      expect_val("lw_alu_src", S_ASRC, 64'd1);
      expect_val("lw_sign_ext", S_SEXT, 64'd1);
      expect_val("lu_stall", S_STL, 64'd1);
      expect_val("lu_stall_b", B_STL, 64'd1);
      drain();
      step();
      expect_val("lu_bubble", S_XV, 64'd0);
      expect_val("lu_m_valid", S_MV, 64'd1);
      expect_val("lu_m_memreg", S_MMR, 64'd1);
      expect_val("lu_m_mask", S_MLM, 64'd2);
      expect_val("lu_m_dest", S_MDST, 64'd8);
      expect_val("lu_m_rw", S_MRW, 64'd1);
      expect_val("lu_stall_once", S_STL, 64'd0);
      drain();
      step();
      expect_val("addu_in_x", S_XV, 64'd1);
      expect_val("addu_aluop", S_ALUOP, 64'd0);
      expect_val("addu_asrc", S_ASRC, 64'd0);
      expect_val("addu_fa", S_FA, 64'd0);
      expect_val("addu_m_bubble", S_MV, 64'd0);
      drain();

      // forwarding from ADDIU $8
      drive(ADDI8, 1'b1);
      step();
      expect_val("addiu_asrc", S_ASRC, 64'd1);
      expect_val("addiu_fa", S_FA, 64'd0);
      drain();
      drive(ADDU9, 1'b1);
      step();
      expect_val("fwd_a", S_FA, 64'd1);
      expect_val("fwd_b", S_FB, 64'd1);
      expect_val("fwd_no_stall", S_STL, 64'd0);
      drain();
      drive(ADDI0, 1'b1);
      step();
      drive(ADDU0, 1'b1);
      step();
      expect_val("r0_fwd_a", S_FA, 64'd0);
      expect_val("r0_fwd_b", S_FB, 64'd0);
      expect_val("r0_x_valid", S_XV, 64'd1);
      drain();

      // JAL then JR $31
      drive(JAL, 1'b1);
      step();
      drive(JR31, 1'b1);
      expect_val("jal_x_jump", S_J, 64'd1);
      expect_val("jal_no_flush_ds", S_FL, 64'd0);
      expect_val("jal_flush_b", B_FL, 64'd1);
      drain();
      step();
      expect_val("jr_x_jr", S_JR, 64'd1);
      expect_val("jr_x_valid", S_XV, 64'd1);
      expect_val("jr_fwd_a", S_FA, 64'd1);
      expect_val("jr_fwd_b", S_FB, 64'd0);
      expect_val("jal_m_rw", S_MRW, 64'd1);
      expect_val("jal_m_link", S_MLK, 64'd1);
      expect_val("jal_m_dest", S_MDST, 64'd31);
      expect_val("jal_flushed_b", B_XV, 64'd0);
      drain();
      drive(NOP, 1'b1);
      step();
      expect_val("jr_m_valid", S_MV, 64'd1);
      expect_val("jr_m_rw", S_MRW, 64'd0);
      expect_val("jr_m_link", S_MLK, 64'd0);
      expect_val("nop_aluop", S_ALUOP, 64'd8);
      drain();

      // BEQ taken
      drive(BEQ, 1'b1);
      step();
      branch_taken_x = 1'b1;
      drive(ADDI8, 1'b1);
      expect_val("beq_branch", S_BR, 64'd1);
      expect_val("beq_brctrl", S_BRC, 64'd0);
      expect_val("beq_flush_ds", S_FL, 64'd0);
      expect_val("beq_flush_b", B_FL, 64'd1);
      drain();
      step();
      branch_taken_x = 1'b0;
      expect_val("slot_exec", S_XV, 64'd1);
      expect_val("slot_killed_b", B_XV, 64'd0);
      drain();

      // illegal instructions: three, then two more for saturation
      for (int i = 0; i < 3; i++) begin
         drive(ILL, 1'b1);
         step();
         expect_val("ill_bubble", S_XV, 64'd0);
         drain();
      end
      expect_val("ill_cnt3", S_CNT, 64'd3);
      expect_val("ill_cnt3_b", B_CNT, 64'd3);
      expect_val("ill_m_valid", S_MV, 64'd0);
      expect_val("ill_m_rw", S_MRW, 64'd0);
      expect_val("ill_m_mw", S_MMW, 64'd0);
      drain();
      for (int i = 0; i < 2; i++) begin
         drive(ILL, 1'b1);
         step();
      end
      expect_val("ill_cnt5", S_CNT, 64'd5);
      expect_val("ill_sat_b", B_CNT, 64'd3);
      drain();

      // stall_ext with LW in M
      drive(LW8, 1'b1);
      step();
      drive(NOP, 1'b1);
      step();
      stall_ext = 1'b1;
      drive(ILL, 1'b1);
      for (int i = 0; i < 4; i++) begin
         expect_val("hold_x_valid", S_XV, 64'd1);
         expect_val("hold_aluop", S_ALUOP, 64'd8);
         expect_val("hold_m_valid", S_MV, 64'd1);
         expect_val("hold_m_memreg", S_MMR, 64'd1);
         expect_val("hold_m_mask", S_MLM, 64'd2);
         expect_val("hold_m_dest", S_MDST, 64'd8);
         expect_val("hold_stall", S_STL, 64'd1);
         expect_val("hold_flush", S_FL, 64'd0);
         expect_val("hold_cnt", S_CNT, 64'd5);
         drain();
         step();
      end
      rst = 1'b1;
      step();
      expect_val("rst_stall_all", S_ALL, 64'd0);
      expect_val("rst_stall_cnt", S_CNT, 64'd0);
      expect_val("rst_stall_all_b", B_ALL, 64'd0);
      expect_val("rst_stall_cnt_b", B_CNT, 64'd0);
      drain();
      rst = 1'b0; stall_ext = 1'b0;
      drive(NOP, 1'b0);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/mips150_ctrl_pipe.md
Name: mips150_ctrl_pipe

Overview:
Parametrised pipelined control unit for the MIPS150 core, replacing the flat combinational decoder. It decodes the D-stage instruction and registers the control bundle into the X and M stages with valid bits. It also generates forwarding selects, load-use stall, branch/jump flush and an illegal-instruction counter. It adds JR/JALR decode, which the previous decoder lacks, and instantiates the existing ALUdec for the ALU op.

Parameters:
LOAD_USE_STALL, 1, 1 = insert one bubble on load-use hazard; 0 = never stall (datapath forwards M-stage load data)
BRANCH_DELAY_SLOT, 1, 1 = instruction after branch/jump executes; 0 = it is flushed
CNT_WIDTH, 16, width of the saturating illegal-instruction counter

Ports:
clk  in  1  core clock
rst  in  1  reset, synchronous active-high
instr_d  in  32  D-stage instruction
valid_d  in  1  instr_d is a real instruction
stall_ext  in  1  memory/IO not ready: freeze all stages
branch_taken_x  in  1  datapath: X-stage branch condition true
x_valid  out  1  X-stage holds a live instruction
x_alu_op  out  4  ALUdec output, registered
x_alu_src, x_sign_ext, x_shamt_sel  out  1 each  operand controls (shamt_sel: 0 = shamt, 1 = rs)
x_br_ctrl  out  3  000 BEQ, 001 BNE, 010 BLEZ, 011 BGTZ, 100 BLTZ, 101 BGEZ
x_branch, x_jump, x_jr  out  1 each  control-flow kind in X
fwd_a_x, fwd_b_x  out  2 each  00 = regfile, 01 = M-stage result, others reserved
m_valid  out  1  M-stage live
m_reg_write, m_mem_to_reg, m_link  out  1 each  writeback controls (link = write PC+8)
m_mem_write  out  2  00 none, 01 byte, 10 half, 11 word
m_load_mask  out  3  000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU
m_dest  out  5  writeback register
stall_d  out  1  hold PC and D
flush_d  out  1  kill D instruction
illegal_cnt  out  CNT_WIDTH  saturating count of illegal decodes

Behaviour:
- Decode (combinational on instr_d):
  - Fields per MIPS150 ISA: loads, stores, I-type ALU, R-type ALU/shifts, branches, J, JAL, JR (funct 001000), JALR (funct 001001).
  - dest: rd for R-type and JALR; rt for I-type and loads; 31 for JAL.
  - Stores, branches, J and JR: reg_write = 0.
  - All unused control fields decode to 0, never x.
- Illegal instruction (unknown opcode, unknown R funct, unknown REGIMM rt):
  - Becomes a bubble: valid = 0, reg_write = 0, mem_write = 00.
  - illegal_cnt += 1 when the instruction advances into X and valid_d = 1. Saturates at all-ones.
- Pipeline advance per cycle, priority rst > stall_ext > flush > load-use > normal:
  - rst: x_valid = m_valid = 0; all x_*/m_* = 0; fwd = 00; stall_d = flush_d = 0; illegal_cnt = 0.
  - stall_ext = 1: all stage registers and illegal_cnt hold; stall_d = 1; flush_d = 0.
  - Normal: M <= X; X <= decode(instr_d), x_valid = valid_d and legal.
- Load-use (LOAD_USE_STALL = 1):
  - Condition: X holds a load with x dest != 0, and the D instruction reads that register as rs or rt.
  - Response: stall_d = 1 for exactly one cycle; X receives a bubble; M advances normally.
- Flush (BRANCH_DELAY_SLOT = 0):
  - flush_d = x_valid & ((x_branch & branch_taken_x) | x_jump | x_jr).
  - Next cycle X = bubble and the load-use stall is suppressed.
  - With BRANCH_DELAY_SLOT = 1, flush_d is tied to 0.
- Forwarding (registered with X):
  - fwd_a_x = 01 iff M-stage valid & reg_write & dest != 0 & dest == X rs; fwd_b_x likewise for rt.
  - Computed at the D->X transfer against the stage about to become M.
- Register 0: never a forwarding or hazard source.
- Latency: decode -> X outputs 1 cycle; X -> M 1 cycle.

Test Plan:
- Load-use: LW 0x8C880000, then ADDU 0x01084821 (LOAD_USE_STALL = 1) -> stall_d = 1 for one cycle; x_valid = 0 on the bubble; ADDU enters X the following cycle.
- Forwarding: ADDIU 0x24080005, then ADDU 0x01084821 -> with ADDU in X: fwd_a_x = 01, fwd_b_x = 01. Repeat with rd = 0 -> both 00.
- JAL 0x0C000010 -> M stage: m_reg_write = 1, m_link = 1, m_dest = 31. JR $31 (0x03E00008) -> x_jr = 1, reg_write = 0.
- BEQ with branch_taken_x = 1, BRANCH_DELAY_SLOT = 0 -> flush_d = 1; next x_valid = 0. With BRANCH_DELAY_SLOT = 1 -> flush_d = 0 and the slot instruction executes.
- Illegal 0xFC000000 three times -> illegal_cnt = 3, no writes. CNT_WIDTH = 2 and five illegals -> illegal_cnt = 3 (saturates).
- stall_ext held 4 cycles during LW in M -> all outputs constant. rst asserted mid-stall -> all outputs 0 on the next edge.
